// File: rtl/register_file_block_pkg.sv
// Shared processor constants used by the register file and the write-back block.
//   RF_DATA_W : register data width in bits
//   RF_ADDR_W : register address width (2**RF_ADDR_W registers)
//   ZERO_REG  : index of the hard-wired zero register
package register_file_block_pkg;
  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;
  localparam int ZERO_REG  = 0;
endpackage

// File: rtl/register_file_block_scoreboard.sv
// reg_scoreboard: one pending bit per register, set when an instruction with
// a register destination issues and cleared on write-back.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   set_en_i / set_addr_i      issue strobe and destination
//   clr_en_i / clr_addr_i      write-back strobe and destination
//   rs_addr_i / rt_addr_i      operand addresses being queried
//   rs_blocked_o / rt_blocked_o operand must wait for a write-back
module reg_scoreboard
  import register_file_block_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic              rs_blocked_o,
  output logic              rt_blocked_o
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [NREG-1:0] pend_q, pend_d;

  // Clear first, then set: an issue and a write-back to the same register
  // in one cycle leave it pending (the newer producer is still in flight).
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // A same-cycle write-back releases the operand because the read bypasses it.
  // Queries use pend_q, so a same-cycle issue does not block its own read.
  assign rs_blocked_o = (rs_addr_i != ZADDR) && pend_q[rs_addr_i] &&
                        !(clr_en_i && (clr_addr_i == rs_addr_i));
  assign rt_blocked_o = (rt_addr_i != ZADDR) && pend_q[rt_addr_i] &&
                        !(clr_en_i && (clr_addr_i == rt_addr_i));
endmodule

// File: rtl/register_file_block.sv
// register_file_block: 2**ADDR_W x DATA_W register file with write-back
// bypass, registered operand outputs and a pending-register scoreboard.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   wb_en/wb_addr/wb_data   write-back port
//   issue_en/issue_addr     destination of an instruction leaving decode
//   rd_en/rs_addr/rt_addr   operand read request
//   rs_data/rt_data         registered operand values
//   rd_valid                operands hold a completed read
//   stall                   read request hits a pending register (comb.)
module register_file_block
  import register_file_block_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rd_valid,
  output logic              stall
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [NREG-1:0][DATA_W-1:0] regs_q;
  logic [DATA_W-1:0]           rs_data_q, rs_data_d;
  logic [DATA_W-1:0]           rt_data_q, rt_data_d;
  logic                        rd_valid_q;
  logic                        wr_hit, iss_hit, rs_blk, rt_blk, rd_fire;

  assign wr_hit  = wb_en    && (wb_addr    != ZADDR);
  assign iss_hit = issue_en && (issue_addr != ZADDR);

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .set_en_i     (iss_hit),
    .set_addr_i   (issue_addr),
    .clr_en_i     (wr_hit),
    .clr_addr_i   (wb_addr),
    .rs_addr_i    (rs_addr),
    .rt_addr_i    (rt_addr),
    .rs_blocked_o (rs_blk),
    .rt_blocked_o (rt_blk)
  );

  assign stall   = !reset && rd_en && (rs_blk || rt_blk);
  assign rd_fire = rd_en && !stall;

  // Operand bypass: an in-flight write-back wins over the array; register 0
  // is forced to zero last.
  always_comb begin
    rs_data_d = regs_q[rs_addr];
    if (wr_hit && (wb_addr == rs_addr)) rs_data_d = wb_data;
    if (rs_addr == ZADDR)               rs_data_d = '0;
    rt_data_d = regs_q[rt_addr];
    if (wr_hit && (wb_addr == rt_addr)) rt_data_d = wb_data;
    if (rt_addr == ZADDR)               rt_data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_hit) regs_q[wb_addr] <= wb_data;
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rs_data_q <= rs_data_d;
        rt_data_q <= rt_data_d;
      end
    end
  end

  assign rs_data  = rs_data_q;
  assign rt_data  = rt_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_register_file_block.sv
module tb_register_file_block;
  logic       clk = 1'b0;
  logic       reset = 1'b0, wb_en = 1'b0, issue_en = 1'b0, rd_en = 1'b0;
  logic [2:0] wb_addr = '0, issue_addr = '0, rs_addr = '0, rt_addr = '0;
  logic [7:0] wb_data = '0;
  logic [7:0] rs_data, rt_data;
  logic       rd_valid, stall;

  int checks = 0;
  int failures = 0;

  register_file_block dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .rd_en(rd_en),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .rd_valid(rd_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, wbe;
    logic [2:0] wba;
    logic [7:0] wbd;
    logic       ise;
    logic [2:0] isa;
    logic       rde;
    logic [2:0] rs, rt;
    logic       e_stall, e_vld;
    logic [7:0] e_rs, e_rt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic wbe, logic [2:0] wba, logic [7:0] wbd,
                              logic ise, logic [2:0] isa, logic rde, logic [2:0] rs,
                              logic [2:0] rt, logic es, logic ev, logic [7:0] ers,
                              logic [7:0] ert);
    vec_t v;
    v.rst = rst; v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.ise = ise; v.isa = isa;
    v.rde = rde; v.rs = rs; v.rt = rt; v.e_stall = es; v.e_vld = ev;
    v.e_rs = ers; v.e_rt = ert;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, check stall mid-cycle, check registered
  // outputs just after the rising edge.
  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    reset = v.rst; wb_en = v.wbe; wb_addr = v.wba; wb_data = v.wbd;
    issue_en = v.ise; issue_addr = v.isa; rd_en = v.rde; rs_addr = v.rs; rt_addr = v.rt;
    #1;
    chk({tag, ".stall"}, {7'd0, stall}, {7'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk({tag, ".rd_valid"}, {7'd0, rd_valid}, {7'd0, v.e_vld});
    chk({tag, ".rs_data"}, rs_data, v.e_rs);
    chk({tag, ".rt_data"}, rt_data, v.e_rt);
  endtask

  // Behavioural model: register contents and pending set as plain arrays.
  logic [7:0] m_regs [8];
  bit         m_pend [8];
  logic [7:0] m_rs, m_rt;
  bit         m_vld;

  function automatic bit m_blocked(logic [2:0] a, vec_t v);
    return (a != 0) && m_pend[a] && !(v.wbe && v.wba == a);
  endfunction

  function automatic logic [7:0] m_value(logic [2:0] a, vec_t v);
    if (a == 0) return 8'h00;
    if (v.wbe && v.wba == a) return v.wbd;
    return m_regs[a];
  endfunction

  task automatic m_step(inout vec_t v);
    v.e_stall = !v.rst && v.rde && (m_blocked(v.rs, v) || m_blocked(v.rt, v));
    if (v.rst) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_rs = 0; m_rt = 0; m_vld = 0;
    end else begin
      m_vld = v.rde && !v.e_stall;
      if (m_vld) begin m_rs = m_value(v.rs, v); m_rt = m_value(v.rt, v); end
      if (v.wbe && v.wba != 0) begin m_regs[v.wba] = v.wbd; m_pend[v.wba] = 0; end
      if (v.ise && v.isa != 0) m_pend[v.isa] = 1;
    end
    v.e_vld = m_vld; v.e_rs = m_rs; v.e_rt = m_rt;
  endtask

  vec_t tbl[$];

  initial begin
    //            rst wbe wba wbd    ise isa rde rs rt  stall vld  rs     rt
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 1, 2, 0, 0, 8'h00, 8'h00)); // reset
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 1, 2, 0, 1, 8'h00, 8'h00)); // read after reset
    tbl.push_back(mk(0, 1, 3, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00)); // wb 3
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 3, 0, 0, 1, 8'hA5, 8'h00)); // read 3
    tbl.push_back(mk(0, 1, 0, 8'hFF, 0, 0, 1, 0, 3, 0, 1, 8'h00, 8'hA5)); // wb r0 + read r0
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 8'h00, 8'h00)); // r0 still 0
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 4, 0, 0, 0, 0, 0, 8'h00, 8'h00)); // issue 4
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 4, 3, 1, 0, 8'h00, 8'h00)); // read 4 stalls
    tbl.push_back(mk(0, 1, 4, 8'h3C, 0, 0, 1, 4, 3, 0, 1, 8'h3C, 8'hA5)); // wb 4 bypass
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 4, 1, 0, 1, 8'h3C, 8'h00)); // 4 released
    tbl.push_back(mk(0, 1, 5, 8'h11, 1, 5, 0, 0, 0, 0, 0, 8'h3C, 8'h00)); // issue+wb 5
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 5, 0, 1, 0, 8'h3C, 8'h00)); // 5 pending
    tbl.push_back(mk(0, 1, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 8'h3C, 8'h00)); // wb non-pending 1
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 1, 2, 0, 1, 8'h77, 8'h00)); // read 1
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 6, 1, 6, 1, 0, 1, 8'h00, 8'h77)); // issue+read 6 pre-issue
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 6, 1, 1, 0, 8'h00, 8'h77)); // 6 pending
    tbl.push_back(mk(1, 1, 2, 8'hEE, 1, 7, 1, 6, 1, 0, 0, 8'h00, 8'h00)); // reset overrides all
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 6, 2, 0, 1, 8'h00, 8'h00)); // 6 clear, 2 unwritten
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 7, 5, 0, 1, 8'h00, 8'h00)); // 7 not pending, 5 cleared

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Randomised traffic against the model; first cycle is a reset to sync.
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v.rst = (i == 0) || ($urandom_range(0, 39) == 0);
      v.wbe = $urandom_range(0, 1);
      v.wba = 3'($urandom_range(0, 7));
      v.wbd = 8'($urandom);
      v.ise = ($urandom_range(0, 9) < 3);
      v.isa = 3'($urandom_range(0, 7));
      v.rde = ($urandom_range(0, 9) < 7);
      v.rs  = 3'($urandom_range(0, 7));
      v.rt  = 3'($urandom_range(0, 7));
      m_step(v);
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file_block.md
REGISTER_FILE_BLOCK -- requirements
Module: register_file_block

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W SHALL default to 8 and sets the register data width in bits.
REQ-003 Parameter ADDR_W SHALL default to 3, giving 2**ADDR_W registers.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the single rising-edge clock.
REQ-005 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-006 Port wb_en SHALL be an input, 1 bit wide: write-back strobe from the write-back stage.
REQ-007 Port wb_addr SHALL be an input, ADDR_W bits wide: destination register of the write-back.
REQ-008 Port wb_data SHALL be an input, DATA_W bits wide: write-back result (ans_wb path).
REQ-009 Port issue_en SHALL be an input, 1 bit wide: an instruction with a register destination is leaving decode.
REQ-010 Port issue_addr SHALL be an input, ADDR_W bits wide: destination register of the issuing instruction.
REQ-011 Port rd_en SHALL be an input, 1 bit wide: operand read request.
REQ-012 Port rs_addr and port rt_addr SHALL each be an input, ADDR_W bits wide: source operand addresses.
REQ-013 Port rs_data and port rt_data SHALL each be an output, DATA_W bits wide, driven from registers: operand values.
REQ-014 Port rd_valid SHALL be an output, 1 bit wide, driven from a register: rs_data/rt_data hold a completed read.
REQ-015 Port stall SHALL be an output, 1 bit wide, combinational: the current read request hits a pending register.

Function
REQ-016 Register 0 SHALL always read as zero, and writes to it and issues to it SHALL be ignored.
REQ-017 When wb_en=1 and wb_addr!=0, the block SHALL write wb_data to regs[wb_addr] at the clock edge.
REQ-018 A scoreboard of one pending bit per register SHALL be set by issue_en at issue_addr and cleared by wb_en at wb_addr.
REQ-019 If issue_en and wb_en target the same address in the same cycle, the pending bit SHALL end set (issue wins) and the data SHALL still be written.
REQ-020 An operand SHALL be blocked when its address is nonzero, its pending bit is 1, and there is no same-cycle wb_en to that address.
REQ-021 Port stall SHALL equal rd_en AND (rs blocked OR rt blocked).
REQ-022 When rd_en=1 and stall=0, the block SHALL capture rs_data/rt_data at the next edge and set rd_valid=1, giving 1-cycle read latency.
REQ-023 A read SHALL bypass the array: an address equal to wb_addr with wb_en=1 (nonzero) SHALL return wb_data in that cycle.
REQ-024 When rd_en=0 or stall=1, rd_valid SHALL be 0 at the next edge and rs_data/rt_data SHALL hold their previous values.
REQ-025 A wb_en to a register that is not pending SHALL be legal: the data is written and the pending bit stays 0.
REQ-026 Issue and read in the same cycle SHALL evaluate stall against the pre-issue scoreboard.

Reset
REQ-027 On reset, all registers, all pending bits, rs_data, rt_data and rd_valid SHALL clear to 0 at the next rising edge.
REQ-028 Reset SHALL override wb_en, issue_en and rd_en in the same cycle, so that no write, issue or read takes effect.
REQ-029 While reset is high, stall SHALL be forced to 0.

Structure
REQ-030 DATA_W, ADDR_W and the zero-register index SHALL live in a shared processor package also used by the write-back block.
REQ-031 The scoreboard SHALL be a separate sub-module named reg_scoreboard, with inputs set, clear and query addresses and outputs of blocked flags.
REQ-032 The register array, bypass muxes and output registers SHALL be in register_file_block itself.

Verification
REQ-033 Assert reset for 1 cycle, then read rs=1, rt=2 -> rd_valid=1 next cycle, rs_data=0x00, rt_data=0x00, stall=0.
REQ-034 Write wb 3<-0xA5, then in the next cycle read rs=3 -> rs_data=0xA5 one cycle later; write to register 0 with 0xFF -> register 0 still reads 0x00.
REQ-035 Issue register 4, then read rs=4 -> stall=1 and rd_valid=0; then wb 4<-0x3C with the read held -> stall=0 the same cycle and rs_data=0x3C one cycle later (bypass).
REQ-036 Issue register 5 and wb 5<-0x11 in the same cycle -> register 5 holds 0x11 and is pending; a following read of rs=5 -> stall=1.
REQ-037 With register 6 pending and rd_en=1 stalled, assert reset -> stall=0, and after release a read of rs=6 -> 0x00 with no stall.
